// File: rtl/frame_cfg_pkg.sv
// Shared types and helpers for the column frame strobe writer.
// Holds the FSM state encoding and the command header field layout.
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam int COL_MSB = 31;
    localparam int COL_LSB = 16;
    localparam int IDX_MSB = 15;
    localparam int IDX_LSB = 0;

    // One bit of the one-hot strobe vector: set only at the frame index.
    function automatic logic onehot_strobe(input logic [15:0] idx,
                                           input int pos);
        return idx == 16'(pos);
    endfunction

endpackage

// File: rtl/frame_data_reg.sv
// Row-addressed frame assembly register.
// Each write loads one row; a synchronous clear zeroes the whole frame.
module frame_data_reg #(
    parameter int RowBits = 32,
    parameter int NumRows = 4,
    parameter int RowSelW = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       we,
    input  logic [RowSelW-1:0]         row_sel,
    input  logic [RowBits-1:0]         wdata,
    output logic [RowBits*NumRows-1:0] frame_o
);

    logic [RowBits*NumRows-1:0] frame_q;
    logic [RowBits*NumRows-1:0] frame_d;

    // Merge the incoming word into the selected row.
    always_comb begin
        frame_d = frame_q;
        if (we && (int'(row_sel) < NumRows)) begin
            frame_d[int'(row_sel)*RowBits +: RowBits] = wdata;
        end
    end

    // Frame storage; clear has priority over any load.
    always_ff @(posedge clk) begin
        if (clr) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_o = frame_q;

endmodule

// File: rtl/frame_strobe_writer.sv
// Column-bottom configuration transmitter: assembles one column frame
// from a header + data word stream, then fires a registered one-hot strobe.
module frame_strobe_writer
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int ColumnId        = 0,
    parameter int StrobeCycles    = 1
) (
    input  logic                                UserCLK,
    input  logic                                reset,
    input  logic [FrameBitsPerRow-1:0]          cfg_data,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                busy,
    output logic                                err_sticky,
    output logic [15:0]                         frames_written
);

    localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(NumRows - 1);
    localparam logic [3:0] SC_LAST = 4'(StrobeCycles - 1);

    state_t                     state_q, state_d;
    logic [RW-1:0]              row_q, row_d;
    logic [15:0]                idx_q, idx_d;
    logic                       match_q, match_d;
    logic                       err_q, err_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [15:0]                fw_q, fw_d;
    logic                       ready_q, ready_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic [MaxFramesPerCol-1:0] strobe_oh;
    logic                       load_en;
    logic                       xfer;
    logic                       col_hit;
    logic                       idx_ok;

    assign xfer    = cfg_valid && ready_q;
    assign col_hit = cfg_data[COL_MSB:COL_LSB] == 16'(ColumnId);
    assign idx_ok  = cfg_data[IDX_MSB:IDX_LSB] < 16'(MaxFramesPerCol);

    // Decode the latched frame index into the strobe pattern.
    always_comb begin
        strobe_oh = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            strobe_oh[i] = onehot_strobe(idx_q, i);
        end
    end

    // Next-state, counters and registered-output precompute.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        match_d = match_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        fw_d    = fw_q;
        load_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    idx_d   = cfg_data[IDX_MSB:IDX_LSB];
                    match_d = col_hit && idx_ok;
                    if (col_hit && !idx_ok) begin
                        err_d = 1'b1;
                    end
                    row_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    load_en = match_q;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = match_q ? S_SETUP : S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                fw_d    = fw_q + 16'd1;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == SC_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d  = (state_d == S_IDLE) || (state_d == S_DATA);
        strobe_d = (state_d == S_STROBE) ? strobe_oh : '0;
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            idx_q    <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            fw_q     <= '0;
            ready_q  <= 1'b1;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            match_q  <= match_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            fw_q     <= fw_d;
            ready_q  <= ready_d;
            strobe_q <= strobe_d;
        end
    end

    frame_data_reg #(
        .RowBits (FrameBitsPerRow),
        .NumRows (NumRows),
        .RowSelW (RW)
    ) u_frame (
        .clk     (UserCLK),
        .clr     (reset),
        .we      (load_en),
        .row_sel (row_q),
        .wdata   (cfg_data),
        .frame_o (FrameData)
    );

    assign cfg_ready      = ready_q;
    assign FrameStrobe    = strobe_q;
    assign busy           = state_q != S_IDLE;
    assign err_sticky     = err_q;
    assign frames_written = fw_q;

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Self-checking bench for frame_strobe_writer.
// Directed and randomized commands against a behavioural column model.
module tb_frame_strobe_writer;

    localparam int NR  = 4;
    localparam int CID = 3;
    localparam int SC  = 2;
    localparam int MF  = 20;

    logic           UserCLK = 1'b0;
    logic           reset   = 1'b1;
    logic [31:0]    cfg_data = '0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [127:0]   FrameData;
    logic [MF-1:0]  FrameStrobe;
    logic           busy;
    logic           err_sticky;
    logic [15:0]    frames_written;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_fd[NR];
    logic [15:0] m_fw;
    logic        m_err;
    logic [31:0] cmd_data[NR];

    frame_strobe_writer #(
        .MaxFramesPerCol (MF),
        .FrameBitsPerRow (32),
        .NumRows         (NR),
        .ColumnId        (CID),
        .StrobeCycles    (SC)
    ) dut (
        .UserCLK        (UserCLK),
        .reset          (reset),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .err_sticky     (err_sticky),
        .frames_written (frames_written)
    );

    always #5 UserCLK = ~UserCLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_frame();
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < NR; k++) begin
            r = r | (128'(m_fd[k]) << (32 * k));
        end
        return r;
    endfunction

    function automatic logic [MF-1:0] exp_strobe(input logic [15:0] idx);
        logic [MF-1:0] one;
        one = 1;
        if (idx < 16'(MF)) return one << idx;
        return '0;
    endfunction

    // Present a word (called at a negedge) and wait until it is taken.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge UserCLK);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 128'(cfg_ready), 128'(1));
        @(negedge UserCLK);
        cfg_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [15:0] col, input logic [15:0] idx,
                           input bit gaps, input bit hold_next,
                           input logic [31:0] next_hdr);
        bit match;
        logic [MF-1:0] es;
        match = (col == 16'(CID)) && (idx < 16'(MF));
        send_word({col, idx});
        for (int k = 0; k < NR; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge UserCLK);
            send_word(cmd_data[k]);
        end
        if (hold_next) begin
            cfg_valid = 1'b1;
            cfg_data  = next_hdr;
        end
        if (col == 16'(CID) && idx >= 16'(MF)) m_err = 1'b1;
        if (match) begin
            for (int k = 0; k < NR; k++) m_fd[k] = cmd_data[k];
            m_fw = m_fw + 16'd1;
            for (int off = 1; off <= SC + 3; off++) begin
                es = (off >= 2 && off <= SC + 1) ? exp_strobe(idx) : '0;
                chk($sformatf("strobe_off%0d", off), 128'(FrameStrobe),
                    128'(es));
                chk($sformatf("ready_off%0d", off), 128'(cfg_ready),
                    128'(off == SC + 3));
                chk($sformatf("busy_off%0d", off), 128'(busy),
                    128'(off != SC + 3));
                if (off < SC + 3) @(negedge UserCLK);
            end
        end else begin
            chk("nomatch_strobe", 128'(FrameStrobe), 128'(0));
            chk("nomatch_ready", 128'(cfg_ready), 128'(1));
        end
        chk("frame", FrameData, model_frame());
        chk("frames_written", 128'(frames_written), 128'(m_fw));
        chk("err_sticky", 128'(err_sticky), 128'(m_err));
    endtask

    initial begin
        logic [15:0] cur_col, cur_idx, nxt_col, nxt_idx;
        bit hold;

        for (int k = 0; k < NR; k++) m_fd[k] = '0;
        m_fw  = '0;
        m_err = 1'b0;

        repeat (3) @(negedge UserCLK);
        chk("rst_ready", 128'(cfg_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_frame", FrameData, 128'(0));
        chk("rst_strobe", 128'(FrameStrobe), 128'(0));
        chk("rst_err", 128'(err_sticky), 128'(0));
        chk("rst_fw", 128'(frames_written), 128'(0));
        reset = 1'b0;
        @(negedge UserCLK);

        // Back-to-back matching command
        for (int k = 0; k < NR; k++) cmd_data[k] = 32'hA0 + 32'(k);
        run_cmd(16'h0003, 16'h0005, 1'b0, 1'b0, 32'h0);
        chk("b2b_frame", FrameData,
            {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Column mismatch
        for (int k = 0; k < NR; k++) cmd_data[k] = $urandom;
        run_cmd(16'h0007, 16'h0002, 1'b0, 1'b0, 32'h0);

        // Index out of range
        for (int k = 0; k < NR; k++) cmd_data[k] = $urandom;
        run_cmd(16'h0003, 16'h0014, 1'b0, 1'b0, 32'h0);

        // Random traffic with gaps and held headers
        nxt_col = 16'(CID);
        nxt_idx = 16'($urandom_range(0, MF - 1));
        for (int i = 0; i < 24; i++) begin
            cur_col = nxt_col;
            cur_idx = nxt_idx;
            nxt_col = ($urandom_range(0, 3) == 0) ?
                      16'($urandom_range(0, 7)) : 16'(CID);
            nxt_idx = 16'($urandom_range(0, MF + 3));
            for (int k = 0; k < NR; k++) cmd_data[k] = $urandom;
            hold = (i < 23) && ($urandom_range(0, 1) == 1);
            run_cmd(cur_col, cur_idx, 1'b1, hold, {nxt_col, nxt_idx});
        end
        chk("err_held", 128'(err_sticky), 128'(1));

        // Reset during the strobe
        for (int k = 0; k < NR; k++) cmd_data[k] = $urandom;
        send_word(32'h0003_0001);
        for (int k = 0; k < NR; k++) send_word(cmd_data[k]);
        @(negedge UserCLK);
        chk("rst_mid_strobe_on", 128'(FrameStrobe), 128'(exp_strobe(1)));
        reset = 1'b1;
        @(negedge UserCLK);
        reset = 1'b0;
        chk("rst_mid_strobe", 128'(FrameStrobe), 128'(0));
        chk("rst_mid_frame", FrameData, 128'(0));
        chk("rst_mid_ready", 128'(cfg_ready), 128'(1));
        chk("rst_mid_fw", 128'(frames_written), 128'(0));
        chk("rst_mid_err", 128'(err_sticky), 128'(0));
        for (int k = 0; k < NR; k++) m_fd[k] = '0;
        m_fw  = '0;
        m_err = 1'b0;
        @(negedge UserCLK);

        // Counter wrap
        force dut.fw_q = 16'hFFFF;
        @(negedge UserCLK);
        release dut.fw_q;
        @(negedge UserCLK);
        chk("fw_preload", 128'(frames_written), 128'(16'hFFFF));
        m_fw = 16'hFFFF;
        for (int k = 0; k < NR; k++) cmd_data[k] = $urandom;
        run_cmd(16'h0003, 16'h0013, 1'b0, 1'b0, 32'h0);
        chk("fw_wrap", 128'(frames_written), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
